gate_truth_checker: RTL
=======================

Name: gate_truth_checker

Overview:
Sequential stimulus-and-check stage for the single-gate primitives (and, or, xor, ...). It drives every input combination into a gate under test, waits a settle interval, and samples the gate output. Each sample is compared against a parameterised expected truth table, and the block reports pass/fail, an error count and the first failing vector. It sits directly upstream of the gate (it feeds `dut_in`) and consumes the gate's output.

Parameters:
N_IN, 2, number of gate inputs (1..4); N_VEC = 2**N_IN vectors per sweep
SETTLE, 2, cycles to hold each vector before sampling (>=1)
EXP_TT, 4'b1000, expected truth table, N_VEC bits; bit v = expected output for input vector v (default = 2-input AND)
CNT_W, 4, width of error counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a sweep; sampled only in IDLE
dut_in  out  N_IN  input vector driven to gate under test; dut_in[0] = input a
dut_out  in  1  output of gate under test
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at sweep end
pass  out  1  1 when the last completed sweep had zero errors; held until next start
err_cnt  out  CNT_W  mismatches in current/last sweep, saturating
first_err_valid  out  1  at least one mismatch in current/last sweep
first_err_vec  out  N_IN  vector of first mismatch; valid when first_err_valid=1

Behaviour:
- Reset (async, rst_n=0): state IDLE, dut_in=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_vec=0, vec=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE:
  - start=1 at an edge → SETTLE.
  - On that transition: vec=0, dut_in=0, settle cnt=0, err_cnt=0, first_err_valid=0, pass=0, busy=1.
- SETTLE: dut_in=vec. Each edge: if cnt==SETTLE-1 → SAMPLE, else cnt++. Occupies exactly SETTLE cycles.
- SAMPLE: one cycle.
  - At the edge, compare dut_out with EXP_TT[vec].
  - On mismatch: err_cnt++ (saturating at 2**CNT_W-1). If first_err_valid=0, set first_err_vec=vec and first_err_valid=1.
  - If vec==N_VEC-1 → DONE. Otherwise vec++, dut_in=vec+1, cnt=0 → SETTLE.
- DONE: one cycle.
  - done=1, busy=0, pass=(err_cnt==0), dut_in=0.
  - Next edge → IDLE with done=0.
- Latency: start accepted at edge E0; done is high in the cycle following edge E0 + N_VEC*(SETTLE+1). Defaults give 12 edges.
- start is ignored in SETTLE, SAMPLE and DONE; there is no queuing.
- Results (pass, err_cnt, first_err_*) persist in IDLE until the next accepted start.
- Error count uses exactly the mismatches sampled; no double count per vector.
- Reset mid-sweep: immediate return to reset values. No done pulse and no partial results retained.
- dut_out is sampled only in SAMPLE; its value in other states has no effect.

Optional Feature:
GATE_CHECK_ABORT_EN
- Defined: extra input port `abort` (1 bit).
  - abort=1 at an edge in SETTLE or SAMPLE → IDLE with busy=0, pass=0, dut_in=0, done not pulsed.
  - err_cnt and first_err_* keep their values at the time of abort.
  - abort in IDLE or DONE is ignored.
  - If abort and the final SAMPLE edge coincide, abort wins.
- Not defined: no abort port; every sweep runs to completion.

Test Plan:
- Defaults, connect a real 2-input AND, pulse start for 1 cycle → dut_in steps 0,1,2,3 every 3 cycles; done pulses 12 edges after start; pass=1, err_cnt=0, first_err_valid=0.
- Defaults, DUT replaced by NAND → err_cnt=4, first_err_valid=1, first_err_vec=0, pass=0.
- Defaults, dut_out stuck at 0 → err_cnt=1, first_err_vec=3, pass=0; a second start clears the results and repeats the identical outcome.
- start held high for 20 cycles → exactly one sweep per acceptance; the re-accept happens only in IDLE, i.e. done pulses at 12, then the next sweep starts from the IDLE cycle.
- N_IN=3, CNT_W=2, EXP_TT=8'h00, dut_out tied 1 → err_cnt saturates at 3, first_err_vec=0.
- rst_n low during vector 2 SETTLE → all outputs reset asynchronously (before next edge), no done pulse. With GATE_CHECK_ABORT_EN, abort in vector 1 → IDLE, done stays 0, dut_in=0.

Source files
------------

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - exhaustive truth-table sweep and check of a single gate
// Optional feature macro: GATE_CHECK_ABORT_EN (adds the abort input).
// Sweeps every input vector into the gate, holds each for SETTLE cycles,
// samples the gate output once and compares it with EXP_TT[vector].
module gate_truth_checker #(
  parameter int                     N_IN   = 2,
  parameter int                     SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0]   EXP_TT = 4'b1000,
  parameter int                     CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef GATE_CHECK_ABORT_EN
  input  logic              abort,
`endif
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_err_valid,
  output logic [N_IN-1:0]   first_err_vec
);

  localparam int N_VEC = 1 << N_IN;
  localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = N_IN'(N_VEC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [N_IN-1:0]  vec;
  logic [SC_W-1:0]  settle_cnt;

  logic             abort_req;
  logic             accept;
  logic             in_run;
  logic             settle_end;
  logic             sample_fire;
  logic             last_vec;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt_nxt;

`ifdef GATE_CHECK_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Abort only has meaning while vectors are being driven or sampled.
  assign in_run      = (state == S_SETTLE) || (state == S_SAMPLE);
  assign accept      = (state == S_IDLE) && start;
  assign settle_end  = (state == S_SETTLE) && (settle_cnt == SETTLE_LAST);
  assign sample_fire = (state == S_SAMPLE) && !abort_req;
  assign last_vec    = (vec == VEC_LAST);

  // Compare the gate output with the expected bit; saturate the count.
  always_comb begin
    mismatch    = (dut_out != EXP_TT[vec]);
    err_cnt_nxt = err_cnt;
    if (mismatch && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt_nxt = err_cnt + 1'b1;
    end
  end

  // Next-state selection; abort takes priority over the final sample.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (abort_req)       state_nxt = S_IDLE;
        else if (settle_end) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort_req)     state_nxt = S_IDLE;
        else if (last_vec) state_nxt = S_DONE;
        else               state_nxt = S_SETTLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Vector index and the vector presented to the gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec    <= '0;
      dut_in <= '0;
    end else if (accept) begin
      vec    <= '0;
      dut_in <= '0;
    end else if (in_run && abort_req) begin
      dut_in <= '0;
    end else if (sample_fire) begin
      if (last_vec) begin
        dut_in <= '0;
      end else begin
        vec    <= vec + 1'b1;
        dut_in <= vec + 1'b1;
      end
    end
  end

  // Settle counter: restarts for every vector, counts SETTLE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (accept || sample_fire) begin
      settle_cnt <= '0;
    end else if ((state == S_SETTLE) && !abort_req && !settle_end) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Busy spans the whole sweep; done is a single-cycle pulse entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy <= 1'b1;
      end else if (in_run && abort_req) begin
        busy <= 1'b0;
      end else if (sample_fire && last_vec) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  // Result registers: cleared on accept, updated per sample, held in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (accept) begin
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (in_run && abort_req) begin
      pass <= 1'b0;
    end else if (sample_fire) begin
      err_cnt <= err_cnt_nxt;
      if (mismatch && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_vec   <= vec;
      end
      if (last_vec) begin
        pass <= (err_cnt_nxt == '0);
      end
    end
  end

endmodule
